// File: rtl/rx_word_aligner_pkg.sv
// Shared SerDes definitions used by the receive word aligner.
//   DEF_PWIDTH       : default parallel word width of the SIPO datapath
//   DEF_SYNC_PATTERN : default alignment word inserted by the transmitter
//   align_state_e    : aligner FSM state encoding
package simple_serdes_pkg;

    localparam int          DEF_PWIDTH       = 20;
    localparam logic [19:0] DEF_SYNC_PATTERN = 20'h5F0A3;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } align_state_e;

endpackage

// File: rtl/rx_word_aligner_if.sv
// Aligner stream bundle: unaligned receive side plus aligned output side.
//   rx_lock, rx_data                                     : SIPO -> aligner
//   data, valid, sync, aligned, bit_offset, realign_cnt  : aligner -> consumer
// master = the side that drives the receive words, slave = the aligner.
interface rx_word_aligner_if #(
    parameter int PWIDTH = simple_serdes_pkg::DEF_PWIDTH
);
    localparam int OW = $clog2(PWIDTH);

    logic              rx_lock;
    logic [PWIDTH-1:0] rx_data;
    logic [PWIDTH-1:0] data;
    logic              valid;
    logic              sync;
    logic              aligned;
    logic [OW-1:0]     bit_offset;
    logic [7:0]        realign_cnt;

    modport master (
        output rx_lock, rx_data,
        input  data, valid, sync, aligned, bit_offset, realign_cnt
    );

    modport slave (
        input  rx_lock, rx_data,
        output data, valid, sync, aligned, bit_offset, realign_cnt
    );

endinterface

// File: rtl/rx_word_aligner_search.sv
// Combinational sync search over a two-word window.
//   win_i      : {current word, previous word}, bit 0 earliest
//   hit        : sync pattern found at some offset 0..PWIDTH-1
//   hit_offset : lowest offset at which it was found (0 when no hit)
module rx_align_search #(
    parameter int                PWIDTH       = simple_serdes_pkg::DEF_PWIDTH,
    parameter logic [PWIDTH-1:0] SYNC_PATTERN = PWIDTH'(simple_serdes_pkg::DEF_SYNC_PATTERN),
    parameter int                OW           = $clog2(PWIDTH)
) (
    input  logic [2*PWIDTH-1:0] win_i,
    output logic                hit,
    output logic [OW-1:0]       hit_offset
);

    logic [PWIDTH-1:0] match;

    for (genvar k = 0; k < PWIDTH; k++) begin : g_cmp
        assign match[k] = (win_i[k +: PWIDTH] == SYNC_PATTERN);
    end

    // Scan from the top down so the lowest matching offset is the one left standing.
    always_comb begin
        hit        = |match;
        hit_offset = '0;
        for (int k = PWIDTH - 1; k >= 0; k--) begin
            if (match[k]) hit_offset = OW'(k);
        end
    end

endmodule

// File: rtl/rx_word_aligner.sv
// Receive word aligner: finds the sync word bit offset in the SIPO stream,
// verifies it LOCK_COUNT times, then re-frames every word at that offset.
//   i_clk, i_rst_n : recovered parallel clock, async active-low reset
//   i_rx_lock      : SIPO lock; low forces HUNT and suppresses matching
//   i_rx_data      : unaligned word, bit 0 earliest
//   o_data         : word at the latched offset (1-cycle latency)
//   o_valid/o_sync : payload / sync word flags (LOCKED only)
//   o_aligned      : state is LOCKED
//   o_bit_offset   : latched offset
//   o_realign_cnt  : LOCKED->HUNT transitions, saturating
module rx_word_aligner
    import simple_serdes_pkg::*;
#(
    parameter int                PWIDTH       = DEF_PWIDTH,
    parameter logic [PWIDTH-1:0] SYNC_PATTERN = PWIDTH'(DEF_SYNC_PATTERN),
    parameter int                LOCK_COUNT   = 4,
    parameter int                MAX_GAP      = 64
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_rx_lock,
    input  logic [PWIDTH-1:0]         i_rx_data,
    output logic [PWIDTH-1:0]         o_data,
    output logic                      o_valid,
    output logic                      o_sync,
    output logic                      o_aligned,
    output logic [$clog2(PWIDTH)-1:0] o_bit_offset,
    output logic [7:0]                o_realign_cnt
);

    localparam int OW = $clog2(PWIDTH);
    localparam int VW = $clog2(LOCK_COUNT + 1);
    localparam int GW = $clog2(MAX_GAP + 1);

    align_state_e       state_q;
    logic [PWIDTH-1:0]  prev_q;
    logic [PWIDTH-1:0]  data_q;
    logic               valid_q;
    logic               sync_q;
    logic               aligned_q;
    logic [OW-1:0]      offset_q;
    logic [7:0]         realign_q;
    logic [7:0]         realign_d;
    logic [VW-1:0]      vcnt_q;
    logic [GW-1:0]      gap_q;

    logic [2*PWIDTH-1:0] win;
    logic [PWIDTH-1:0]   cand_sel;
    logic                sync_at_off;
    logic                hit;
    logic [OW-1:0]       hit_offset;

    assign win         = {i_rx_data, prev_q};
    assign cand_sel    = win[offset_q +: PWIDTH];
    assign sync_at_off = (cand_sel == SYNC_PATTERN);
    assign realign_d   = (realign_q == 8'hFF) ? realign_q : realign_q + 8'd1;

    rx_align_search #(
        .PWIDTH       (PWIDTH),
        .SYNC_PATTERN (SYNC_PATTERN),
        .OW           (OW)
    ) u_search (
        .win_i      (win),
        .hit        (hit),
        .hit_offset (hit_offset)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= HUNT;
            prev_q    <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            sync_q    <= 1'b0;
            aligned_q <= 1'b0;
            offset_q  <= '0;
            realign_q <= '0;
            vcnt_q    <= '0;
            gap_q     <= '0;
        end else begin
            prev_q  <= i_rx_data;
            // The word at the latched offset is forwarded in every state; only the flags gate it.
            data_q  <= cand_sel;
            valid_q <= 1'b0;
            sync_q  <= 1'b0;
            if (!i_rx_lock) begin
                // Lost SIPO lock overrides any match or gap expiry this cycle.
                if (state_q == LOCKED) realign_q <= realign_d;
                state_q   <= HUNT;
                aligned_q <= 1'b0;
                vcnt_q    <= '0;
                gap_q     <= '0;
            end else begin
                unique case (state_q)
                    HUNT: begin
                        if (hit) begin
                            offset_q <= hit_offset;
                            vcnt_q   <= VW'(1);
                            gap_q    <= '0;
                            if (LOCK_COUNT == 1) begin
                                state_q   <= LOCKED;
                                aligned_q <= 1'b1;
                            end else begin
                                state_q <= VERIFY;
                            end
                        end
                    end
                    VERIFY: begin
                        if (sync_at_off) begin
                            vcnt_q <= vcnt_q + VW'(1);
                            if (vcnt_q == VW'(LOCK_COUNT - 1)) begin
                                state_q   <= LOCKED;
                                aligned_q <= 1'b1;
                                gap_q     <= '0;
                            end
                        end else begin
                            state_q <= HUNT;
                            vcnt_q  <= '0;
                        end
                    end
                    LOCKED: begin
                        if (sync_at_off) begin
                            sync_q <= 1'b1;
                            gap_q  <= '0;
                        end else if (gap_q == GW'(MAX_GAP - 1)) begin
                            // Too long without a sync word: drop the word and re-hunt.
                            state_q   <= HUNT;
                            aligned_q <= 1'b0;
                            vcnt_q    <= '0;
                            gap_q     <= '0;
                            realign_q <= realign_d;
                        end else begin
                            valid_q <= 1'b1;
                            gap_q   <= gap_q + GW'(1);
                        end
                    end
                    default: begin
                        state_q   <= HUNT;
                        aligned_q <= 1'b0;
                        vcnt_q    <= '0;
                        gap_q     <= '0;
                    end
                endcase
            end
        end
    end

    assign o_data        = data_q;
    assign o_valid       = valid_q;
    assign o_sync        = sync_q;
    assign o_aligned     = aligned_q;
    assign o_bit_offset  = offset_q;
    assign o_realign_cnt = realign_q;

endmodule

// File: doc/rx_word_aligner.md
RX_WORD_ALIGNER -- requirements
Module: rx_word_aligner

Interface
REQ-001 SHALL have parameter PWIDTH, default 20: parallel word width; matches the SIPO datapath.
REQ-002 SHALL have parameter SYNC_PATTERN, default 20'h5F0A3: PWIDTH-bit alignment word inserted by the transmitter.
REQ-003 SHALL have parameter LOCK_COUNT, default 4: consecutive sync words required to declare alignment (range 1..15).
REQ-004 SHALL have parameter MAX_GAP, default 64: maximum number of words allowed between sync words while locked (range 2..1023).
REQ-005 SHALL have port i_clk, input, 1: recovered parallel clock; the single clock for the block.
REQ-006 SHALL have port i_rst_n, input, 1: asynchronous active-low reset.
REQ-007 SHALL have port i_rx_lock, input, 1: SIPO lock status.
REQ-008 SHALL have port i_rx_data, input, PWIDTH: unaligned parallel word; bit 0 is the earliest received bit.
REQ-009 SHALL have port o_data, output, PWIDTH: aligned word.
REQ-010 SHALL have port o_valid, output, 1: o_data is a payload word.
REQ-011 SHALL have port o_sync, output, 1: o_data is a sync word; single-cycle flag.
REQ-012 SHALL have port o_aligned, output, 1: the block is in state LOCKED.
REQ-013 SHALL have port o_bit_offset, output, clog2(PWIDTH): the latched alignment offset.
REQ-014 SHALL have port o_realign_cnt, output, 8: count of LOCKED->HUNT transitions; saturates at 255.

Function
REQ-015 SHALL register the previous input word and form window W = {i_rx_data, prev_word} of 2*PWIDTH bits.
REQ-016 SHALL define candidate(k) = W[k+PWIDTH-1:k] for k = 0..PWIDTH-1.
REQ-017 SHALL implement three states: HUNT, VERIFY, LOCKED.
REQ-018 In HUNT, SHALL compare all PWIDTH candidates in parallel; on any match, SHALL latch the lowest matching k, set the verify count to 1 and move to VERIFY.
REQ-019 In VERIFY, a match at the latched offset SHALL increment the count; when the count reaches LOCK_COUNT, the state SHALL move to LOCKED.
REQ-020 In VERIFY, a mismatch SHALL return the state to HUNT and clear the count.
REQ-021 With LOCK_COUNT=1, the first HUNT match SHALL go directly to LOCKED.
REQ-022 In LOCKED, each cycle SHALL register o_data = candidate(offset) with one-cycle latency.
REQ-023 In LOCKED, a match SHALL assert o_sync=1 and o_valid=0 and clear the gap counter.
REQ-024 In LOCKED, a non-match SHALL assert o_valid=1 and increment the gap counter.
REQ-025 In LOCKED, when the gap counter would reach MAX_GAP, SHALL move to HUNT, deassert o_valid that cycle and increment o_realign_cnt.
REQ-026 Outside LOCKED, o_valid and o_sync SHALL be 0, and o_data SHALL still be driven from candidate(offset).
REQ-027 i_rx_lock=0 in any state SHALL force HUNT on the next edge, clear all counters except o_realign_cnt, and suppress matching.
REQ-028 i_rx_lock=0 in LOCKED SHALL count as a realign.
REQ-029 If i_rx_lock falls in the same cycle as a sync match or a gap expiry, the i_rx_lock drop SHALL win, and realign SHALL be counted once.
REQ-030 o_bit_offset SHALL change only on a HUNT->VERIFY transition.

Reset
REQ-031 While i_rst_n=0, all of the following SHALL hold: state HUNT, prev_word 0, o_data 0, o_valid 0, o_sync 0, o_aligned 0, o_bit_offset 0, o_realign_cnt 0, verify and gap counters 0.
REQ-032 Reset assertion SHALL be asynchronous; deassertion SHALL be sampled on i_clk.
REQ-033 The first candidate compare after reset SHALL use prev_word=0.

Structure
REQ-034 The shared package simple_serdes_pkg SHALL hold the default PWIDTH, the default SYNC_PATTERN and the aligner state enum.
REQ-035 Sub-module rx_align_search SHALL be combinational: parallel PWIDTH-offset comparator plus lowest-index priority encoder, with outputs hit and hit_offset.
REQ-036 Counters SHALL be sized by clog2 of LOCK_COUNT+1 and MAX_GAP+1.

Verification
REQ-037 Scenario: stream shifted 7 bits; 4 sync words followed by payload 20'h00001, 20'h00002 -> o_bit_offset=7, o_aligned rises after the 4th sync, o_data=20'h00001 with o_valid=1 on the next word.
REQ-038 Scenario: offset 0 (no shift) -> o_bit_offset=0; payload passes unchanged with 1-cycle latency.
REQ-039 Scenario: in VERIFY, after 2 sync words send 20'h12345 -> return to HUNT; o_aligned stays 0; o_realign_cnt stays 0.
REQ-040 Scenario: in LOCKED, send 64 consecutive payload words with no sync -> HUNT on the 64th, o_aligned=0, o_realign_cnt=1; with 63 payload words then a sync -> stays LOCKED.
REQ-041 Scenario: in LOCKED, i_rx_lock=0 for 1 cycle -> HUNT next edge, o_valid=0, o_realign_cnt increments by 1; re-lock at offset 13 -> o_bit_offset=13.
REQ-042 Scenario: assert i_rst_n=0 mid-LOCKED, asynchronously between edges -> all outputs 0 immediately.
